prod_gen: RTL and testbench

Pseudo-random stimulus producer for the consumer/accumulator path. Drives a valid strobe and an 8-bit data word from an internal 16-bit LFSR. Data forms non-decreasing runs of RUN_LEN valid samples, then restarts from a small value, so downstream "sum while non-decreasing" logic sees both monotonic runs and drops. Purely a source block: no backpressure, no inputs besides clock and reset.

---
 rtl/prod_gen.sv | 63 ++++++
 tb/tb_prod_gen.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/prod_gen.sv
// prod_gen: LFSR-driven stimulus source emitting non-decreasing runs of
// RUN_LEN valid samples, each run restarting from a small value.
module prod_gen #(
  parameter logic [15:0] SEED       = 16'hACE1,
  parameter logic [3:0]  VAL_THRESH = 4'd5,
  parameter int unsigned RUN_LEN    = 8
) (
  input  logic       clk,
  input  logic       rst_b,
  output logic       val,
  output logic [7:0] data
);

  // An all-zero seed would lock the LFSR, so it is replaced by 1.
  localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;
  localparam logic [7:0]  RUN_LAST = 8'(RUN_LEN - 1);
  localparam logic [15:0] TAPS     = 16'hB400;

  logic [15:0] lfsr_q, lfsr_d;
  logic [7:0]  data_q, data_d;
  logic        val_q, val_d;
  logic [7:0]  run_cnt_q, run_cnt_d;
  logic        smp;
  logic [8:0]  sum;

  // Next-state: LFSR step, sample strobe, run accumulation or restart.
  always_comb begin
    smp       = ({1'b0, lfsr_q[2:0]} < VAL_THRESH);
    lfsr_d    = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? TAPS : '0);
    val_d     = smp;
    data_d    = data_q;
    run_cnt_d = run_cnt_q;
    sum       = {1'b0, data_q} + {5'b0, lfsr_q[7:4]};
    if (smp) begin
      if (run_cnt_q == RUN_LAST) begin
        data_d    = {4'b0000, lfsr_q[15:12]};
        run_cnt_d = '0;
      end else begin
        data_d    = sum[8] ? '1 : sum[7:0];
        run_cnt_d = run_cnt_q + 8'd1;
      end
    end
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst_b) begin
      lfsr_q    <= SEED_EFF;
      data_q    <= '0;
      val_q     <= 1'b0;
      run_cnt_q <= '0;
    end else begin
      lfsr_q    <= lfsr_d;
      data_q    <= data_d;
      val_q     <= val_d;
      run_cnt_q <= run_cnt_d;
    end
  end

  assign val  = val_q;
  assign data = data_q;

endmodule

// File: tb/tb_prod_gen.sv
// tb_prod_gen: several prod_gen configurations checked cycle by cycle
// against an arithmetic reference model, plus directed known-value checks.
module tb_prod_gen;

  localparam int NI = 6;

  logic clk = 1'b0;
  logic rst_b = 1'b1;
  logic       val_w  [NI];
  logic [7:0] data_w [NI];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  prod_gen u_def (.clk(clk), .rst_b(rst_b), .val(val_w[0]), .data(data_w[0]));
  prod_gen #(.VAL_THRESH(4'd0)) u_th0 (.clk(clk), .rst_b(rst_b), .val(val_w[1]), .data(data_w[1]));
  prod_gen #(.VAL_THRESH(4'd8)) u_th8 (.clk(clk), .rst_b(rst_b), .val(val_w[2]), .data(data_w[2]));
  prod_gen #(.RUN_LEN(255), .VAL_THRESH(4'd8)) u_long (.clk(clk), .rst_b(rst_b), .val(val_w[3]), .data(data_w[3]));
  prod_gen #(.SEED(16'h0000)) u_s0 (.clk(clk), .rst_b(rst_b), .val(val_w[4]), .data(data_w[4]));
  prod_gen #(.RUN_LEN(1), .SEED(16'h1234), .VAL_THRESH(4'd3)) u_r1 (.clk(clk), .rst_b(rst_b), .val(val_w[5]), .data(data_w[5]));

  typedef struct {
    int seed;
    int thresh;
    int runlen;
    int lfsr;
    int data;
    int val;
    int cnt;
  } model_t;

  model_t m [NI];

  // Behavioural model: one clock edge of the producer in plain integer arithmetic.
  function automatic model_t step(model_t s, bit rst);
    model_t r = s;
    int v;
    if (rst) begin
      r.lfsr = (s.seed == 0) ? 1 : s.seed;
      r.data = 0;
      r.val  = 0;
      r.cnt  = 0;
    end else begin
      v = ((s.lfsr % 8) < s.thresh) ? 1 : 0;
      r.lfsr = (s.lfsr / 2) ^ (((s.lfsr % 2) == 1) ? 46080 : 0);
      r.val = v;
      if (v == 1) begin
        if (s.cnt == s.runlen - 1) begin
          r.data = s.lfsr / 4096;
          r.cnt  = 0;
        end else begin
          r.data = s.data + ((s.lfsr / 16) % 16);
          if (r.data > 255) r.data = 255;
          r.cnt = s.cnt + 1;
        end
      end
    end
    return r;
  endfunction

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  int prev_def;
  bit saw_sat, saw_drop;

  // Advance one clock edge, step all models, compare every instance.
  task automatic tick();
    @(posedge clk);
    for (int i = 0; i < NI; i++) m[i] = step(m[i], rst_b);
    #1;
    for (int i = 0; i < NI; i++) begin
      check($sformatf("val[%0d]", i), int'(val_w[i]), m[i].val);
      check($sformatf("data[%0d]", i), int'(data_w[i]), m[i].data);
    end
    check("th0_never", int'(val_w[1]), m[1].thresh == 0 && !rst_b ? 0 : int'(val_w[1]) & 0);
    if (!rst_b) check("th8_always", int'(val_w[2]), 1);
    if (rst_b) prev_def = 0;
    else if (val_w[0]) begin
      if (m[0].cnt != 0) check("def_nondecr", int'(data_w[0] >= 8'(prev_def)), 1);
      prev_def = int'(data_w[0]);
    end
    if (val_w[3] && data_w[3] == 8'd255) saw_sat = 1'b1;
    if (saw_sat && val_w[3] && data_w[3] <= 8'd15) saw_drop = 1'b1;
    if (val_w[5] && !rst_b) check("r1_restart", int'(data_w[5] <= 8'd15), 1);
  endtask

  task automatic expect_post_reset(input string tag);
    int exp_d [4];
    exp_d = '{14, 21, 24, 33};
    for (int k = 0; k < 4; k++) begin
      tick();
      check($sformatf("%s_val%0d", tag, k), int'(val_w[0]), 1);
      check($sformatf("%s_data%0d", tag, k), int'(data_w[0]), exp_d[k]);
    end
  endtask

  initial begin
    m[0] = '{seed: 16'hACE1, thresh: 5, runlen: 8,   lfsr: 0, data: 0, val: 0, cnt: 0};
    m[1] = '{seed: 16'hACE1, thresh: 0, runlen: 8,   lfsr: 0, data: 0, val: 0, cnt: 0};
    m[2] = '{seed: 16'hACE1, thresh: 8, runlen: 8,   lfsr: 0, data: 0, val: 0, cnt: 0};
    m[3] = '{seed: 16'hACE1, thresh: 8, runlen: 255, lfsr: 0, data: 0, val: 0, cnt: 0};
    m[4] = '{seed: 0,        thresh: 5, runlen: 8,   lfsr: 0, data: 0, val: 0, cnt: 0};
    m[5] = '{seed: 16'h1234, thresh: 3, runlen: 1,   lfsr: 0, data: 0, val: 0, cnt: 0};
    prev_def = 0;
    saw_sat  = 1'b0;
    saw_drop = 1'b0;

    // Reset held: outputs at zero.
    rst_b = 1'b1;
    for (int k = 0; k < 3; k++) tick();
    check("rst_val", int'(val_w[0]), 0);
    check("rst_data", int'(data_w[0]), 0);

    // Release and check the known first samples.
    rst_b = 1'b0;
    expect_post_reset("first");

    // Long free run against the model; long-run instance must saturate then drop.
    for (int k = 0; k < 1000; k++) tick();
    check("long_saturated", int'(saw_sat), 1);
    check("long_dropped", int'(saw_drop), 1);
    check("s0_lfsr_live", int'(m[4].lfsr != 0), 1);

    // One-cycle reset mid-run at a random point.
    for (int k = 0, n = $urandom_range(20, 1); k < n; k++) tick();
    rst_b = 1'b1;
    tick();
    check("mid_rst_val", int'(val_w[0]), 0);
    check("mid_rst_data", int'(data_w[0]), 0);
    rst_b = 1'b0;
    expect_post_reset("again");

    // Random reset pulses sprinkled over a further run.
    for (int k = 0; k < 400; k++) begin
      rst_b = ($urandom_range(49, 0) == 0);
      tick();
    end
    rst_b = 1'b0;
    for (int k = 0; k < 50; k++) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    failures++;
    $display("FAIL timeout observed=running expected=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
